// File: rtl/hft_pkg.sv
// Shared arbitrage-pipeline types: vertex-matrix word layout, relaxation states, widths.
package hft_pkg;

    localparam int NODES        = 16;
    localparam int WEIGHT_WIDTH = 31;
    localparam int PRED_WIDTH   = 3;
    localparam int VERT_WIDTH   = WEIGHT_WIDTH + PRED_WIDTH + 2;

    localparam logic signed [WEIGHT_WIDTH:0] WEIGHT_INF = {1'b0, {WEIGHT_WIDTH{1'b1}}};

    typedef struct packed {
        logic                           rsvd;
        logic [PRED_WIDTH:0]            pred;
        logic signed [WEIGHT_WIDTH:0]   weight;
    } vert_word_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SET,
        RELAX,
        DONE
    } relax_state_t;

endpackage

// File: rtl/relax_cmp.sv
// Edge relaxation compare: decides whether svw+e improves dvw and supplies the new weight.
module relax_cmp
    import hft_pkg::*;
(
    input  logic signed [WEIGHT_WIDTH:0] svw,
    input  logic signed [WEIGHT_WIDTH:0] dvw,
    input  logic signed [WEIGHT_WIDTH:0] e,
    output logic                         do_update,
    output logic signed [WEIGHT_WIDTH:0] new_weight
);

    // One guard bit so the sum of two extreme weights cannot wrap.
    logic signed [WEIGHT_WIDTH+1:0] sum;
    logic signed [WEIGHT_WIDTH+1:0] dvw_ext;

    assign sum        = {svw[WEIGHT_WIDTH], svw} + {e[WEIGHT_WIDTH], e};
    assign dvw_ext    = {dvw[WEIGHT_WIDTH], dvw};
    assign do_update  = (e != '0) && (svw != WEIGHT_INF) && (sum < dvw_ext);
    assign new_weight = sum[WEIGHT_WIDTH:0];

endmodule

// File: rtl/bellman_relax.sv
// Bellman-Ford relaxation engine writing {pred, weight} words into vertmat.
// Optional macro RELAX_EARLY_EXIT_EN: finish after the first pass that makes no update.
module bellman_relax
    import hft_pkg::*;
#(
    parameter int NODES = hft_pkg::NODES
) (
    input  logic                  clk,
    input  logic                  relax_reset,
    input  logic                  relax_start,
    input  logic [PRED_WIDTH:0]   src_vertex,
    input  logic [WEIGHT_WIDTH:0] adjmat_q,
    input  logic [VERT_WIDTH:0]   vertmat_q_a,
    input  logic [VERT_WIDTH:0]   vertmat_q_b,
    output logic [PRED_WIDTH:0]   adjmat_row_addr,
    output logic [PRED_WIDTH:0]   adjmat_col_addr,
    output logic [PRED_WIDTH:0]   vertmat_addr_a,
    output logic [PRED_WIDTH:0]   vertmat_addr_b,
    output logic [VERT_WIDTH:0]   vertmat_data_b,
    output logic                  vertmat_we_b,
    output logic                  relax_busy,
    output logic                  relax_done
);

    localparam logic [PRED_WIDTH:0] LAST = (PRED_WIDTH+1)'(NODES - 1);

    relax_state_t        state_reg, state_next;
    logic [PRED_WIDTH:0] i_reg, i_next;
    logic [PRED_WIDTH:0] j_reg, j_next;
    logic [PRED_WIDTH:0] pass_reg, pass_next;
    logic [PRED_WIDTH:0] src_reg, src_next;
    logic                updated_reg, updated_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    logic                         do_update;
    logic signed [WEIGHT_WIDTH:0] new_weight;
    logic                         last_pass;
    vert_word_t                   wr_word;
    logic                         unused_bits;

    relax_cmp u_cmp (
        .svw        (vertmat_q_a[WEIGHT_WIDTH:0]),
        .dvw        (vertmat_q_b[WEIGHT_WIDTH:0]),
        .e          (adjmat_q),
        .do_update  (do_update),
        .new_weight (new_weight)
    );

    assign unused_bits = ^{vertmat_q_a[VERT_WIDTH:WEIGHT_WIDTH+1],
                           vertmat_q_b[VERT_WIDTH:WEIGHT_WIDTH+1], updated_reg};

`ifdef RELAX_EARLY_EXIT_EN
    // A pass that changed nothing means the distances have converged.
    assign last_pass = (pass_reg == LAST) || !(updated_reg || do_update);
`else
    assign last_pass = (pass_reg == LAST);
`endif

    always_ff @(posedge clk or posedge relax_reset) begin
        if (relax_reset) begin
            state_reg   <= IDLE;
            i_reg       <= '0;
            j_reg       <= '0;
            pass_reg    <= '0;
            src_reg     <= '0;
            updated_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            i_reg       <= i_next;
            j_reg       <= j_next;
            pass_reg    <= pass_next;
            src_reg     <= src_next;
            updated_reg <= updated_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        i_next         = i_reg;
        j_next         = j_reg;
        pass_next      = pass_reg;
        src_next       = src_reg;
        updated_next   = updated_reg;
        busy_next      = busy_reg;
        done_next      = done_reg;
        wr_word        = '0;
        vertmat_we_b   = 1'b0;
        vertmat_addr_b = j_reg;

        case (state_reg)
            IDLE: begin
                if (relax_start) begin
                    src_next   = src_vertex;
                    done_next  = 1'b0;
                    busy_next  = 1'b1;
                    i_next     = '0;
                    state_next = INIT;
                end
            end
            INIT: begin
                vertmat_addr_b = i_reg;
                vertmat_we_b   = 1'b1;
                wr_word.pred   = i_reg;
                wr_word.weight = (i_reg == src_reg) ? '0 : WEIGHT_INF;
                if (i_reg == LAST) begin
                    i_next       = '0;
                    j_next       = '0;
                    pass_next    = (PRED_WIDTH+1)'(1);
                    updated_next = 1'b0;
                    state_next   = SET;
                end else begin
                    i_next = i_reg + 1'b1;
                end
            end
            SET: begin
                state_next = RELAX;
            end
            RELAX: begin
                if (do_update) begin
                    vertmat_we_b   = 1'b1;
                    wr_word.pred   = i_reg;
                    wr_word.weight = new_weight;
                    updated_next   = 1'b1;
                end
                state_next = SET;
                if (j_reg != LAST) begin
                    j_next = j_reg + 1'b1;
                end else begin
                    j_next = '0;
                    if (i_reg != LAST) begin
                        i_next = i_reg + 1'b1;
                    end else begin
                        i_next = '0;
                        if (last_pass) begin
                            state_next = DONE;
                        end else begin
                            pass_next    = pass_reg + 1'b1;
                            updated_next = 1'b0;
                        end
                    end
                end
            end
            DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign vertmat_data_b  = wr_word;
    assign adjmat_row_addr = i_reg;
    assign adjmat_col_addr = j_reg;
    assign vertmat_addr_a  = i_reg;
    assign relax_busy      = busy_reg;
    assign relax_done      = done_reg;

endmodule
